// File: rtl/fpu_round_pkg.sv
// Shared types and constants for the fpu_sub rounding/packing pipeline.
package fpu_round_pkg;

  localparam int unsigned EXP_W = 11;
  localparam int unsigned MAN_W = 52;
  localparam int unsigned SIG_W = MAN_W + 4;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } roundmode_e;

  localparam logic [EXP_W-1:0] EXP_MAX = 11'h7FE;
  localparam logic [EXP_W-1:0] EXP_INF = 11'h7FF;

  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  // sig holds {carry, hidden, mantissa}; guard/round are folded into up/inexact.
  typedef struct packed {
    logic             sign;
    logic [2:0]       rm;
    logic [MAN_W+1:0] sig;
    logic [EXP_W-1:0] exp;
    logic             up;
    logic             inexact;
    logic             zero;
  } s1_t;

  // exp is one bit wider so a rounding carry out of 0x7FF stays visible.
  typedef struct packed {
    logic             sign;
    logic [2:0]       rm;
    logic [EXP_W:0]   exp;
    logic [MAN_W-1:0] mant;
    logic             inexact;
    logic             zero;
  } s2_t;

endpackage

// File: rtl/fpu_sub_round_if.sv
// Handshake and payload bundle between fpu_sub, the rounding stage and its consumer.
interface fpu_sub_round_if;
  import fpu_round_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [SIG_W-1:0] in_man;
  logic [EXP_W-1:0] in_exp;
  logic             in_sticky;
  logic [2:0]       in_rm;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [4:0]       out_flags;

  modport master (
    output in_valid, in_sign, in_man, in_exp, in_sticky, in_rm, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_man, in_exp, in_sticky, in_rm, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fpu_round_decide.sv
// Round-up decision for the RISC-V rounding modes; reserved codes fall back to RNE.
module fpu_round_decide
  import fpu_round_pkg::*;
(
  input  logic [2:0] rm_i,
  input  logic       sign_i,
  input  logic       lsb_i,
  input  logic       g_i,
  input  logic       r_i,
  input  logic       s_i,
  output logic       up_o,
  output logic       inexact_o
);

  always_comb begin
    inexact_o = g_i | r_i | s_i;
    case (rm_i)
      RTZ:     up_o = 1'b0;
      RDN:     up_o = sign_i & inexact_o;
      RUP:     up_o = ~sign_i & inexact_o;
      RMM:     up_o = g_i;
      default: up_o = g_i & (r_i | s_i | lsb_i);
    endcase
  end

endmodule

// File: rtl/fpu_sub_round.sv
// Three-stage round/pack pipeline with a global stall; define FPU_ROUND_FLAGS_EN to
// compute and register the exception flags, otherwise out_flags reads zero.
module fpu_sub_round
  import fpu_round_pkg::*;
(
  input logic            clk,
  input logic            rst,
  fpu_sub_round_if.slave bus_io
);

  logic             adv;
  logic             v1_q, v2_q, v3_q;
  logic             up, inexact;
  s1_t              s1_d, s1_q;
  s2_t              s2_d, s2_q;
  logic [MAN_W+1:0] sum;
  logic             ovf, to_max;
  logic [63:0]      res_d, res_q;

  // Every stage moves together; only a held output can stall the pipe.
  assign adv              = ~v3_q | bus_io.out_ready;
  assign bus_io.in_ready  = adv;
  assign bus_io.out_valid = v3_q;
  assign bus_io.out_result = res_q;

  fpu_round_decide u_decide (
    .rm_i      (bus_io.in_rm),
    .sign_i    (bus_io.in_sign),
    .lsb_i     (bus_io.in_man[2]),
    .g_i       (bus_io.in_man[1]),
    .r_i       (bus_io.in_man[0]),
    .s_i       (bus_io.in_sticky),
    .up_o      (up),
    .inexact_o (inexact)
  );

  always_comb begin
    s1_d.sign    = bus_io.in_sign;
    s1_d.rm      = bus_io.in_rm;
    s1_d.sig     = bus_io.in_man[SIG_W-1:2];
    s1_d.exp     = bus_io.in_exp;
    s1_d.up      = up;
    s1_d.inexact = inexact;
    s1_d.zero    = (bus_io.in_man == '0) && (bus_io.in_exp == '0) && !bus_io.in_sticky;
  end

  always_comb begin
    sum          = s1_q.sig + {{(MAN_W+1){1'b0}}, s1_q.up};
    s2_d.sign    = s1_q.sign;
    s2_d.rm      = s1_q.rm;
    s2_d.inexact = s1_q.inexact;
    s2_d.zero    = s1_q.zero;
    if (sum[MAN_W+1]) begin
      s2_d.mant = sum[MAN_W:1];
      s2_d.exp  = {1'b0, s1_q.exp} + (EXP_W+1)'(1);
    end else begin
      s2_d.mant = sum[MAN_W-1:0];
      // A denormal that rounds up into the hidden bit becomes the smallest normal.
      s2_d.exp  = ((s1_q.exp == '0) && sum[MAN_W]) ? (EXP_W+1)'(1) : {1'b0, s1_q.exp};
    end
  end

  always_comb begin
    ovf    = s2_q.exp >= {1'b0, EXP_INF};
    to_max = (s2_q.rm == RTZ) || ((s2_q.rm == RDN) && !s2_q.sign) ||
             ((s2_q.rm == RUP) && s2_q.sign);
    if (s2_q.zero) begin
      res_d = {(s2_q.rm == RDN), 63'd0};
    end else if (ovf) begin
      res_d = to_max ? {s2_q.sign, EXP_MAX, {MAN_W{1'b1}}} : {s2_q.sign, EXP_INF, {MAN_W{1'b0}}};
    end else begin
      res_d = {s2_q.sign, s2_q.exp[EXP_W-1:0], s2_q.mant};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      res_q <= '0;
    end else if (adv) begin
      v1_q  <= bus_io.in_valid;
      v2_q  <= v1_q;
      v3_q  <= v2_q;
      res_q <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

`ifdef FPU_ROUND_FLAGS_EN
  logic [4:0] flags_d, flags_q;
  logic       nx;

  always_comb begin
    nx      = s2_q.inexact | ovf;
    flags_d = '0;
    if (!s2_q.zero) begin
      flags_d[FLAG_NX] = nx;
      flags_d[FLAG_OF] = ovf;
      flags_d[FLAG_UF] = nx & (res_d[MAN_W +: EXP_W] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (adv) begin
      flags_q <= flags_d;
    end
  end

  assign bus_io.out_flags = flags_q;
`else
  logic unused_inexact;
  assign unused_inexact   = s2_q.inexact;
  assign bus_io.out_flags = '0;
`endif

endmodule

// File: tb/tb_fpu_sub_round.sv
// Randomized scoreboard bench for fpu_sub_round with directed rounding and stall/reset cases.
module tb_fpu_sub_round;
  import fpu_round_pkg::*;

`ifdef FPU_ROUND_FLAGS_EN
  localparam bit FlagsOn = 1'b1;
`else
  localparam bit FlagsOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpu_sub_round_if bus ();

  fpu_sub_round u_dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  flags;
  } exp_t;

  int          n_total = 0;
  int          n_bad = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic        dir_en;
  logic [63:0] dir_res;
  logic [4:0]  dir_flags;
  logic        bp_mode;
  logic        force_ready;
  logic        prev_stall;
  logic [63:0] prev_res;
  logic [4:0]  prev_flags;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Value-level model: round the 54-bit significand by comparing the dropped bits to a half ulp.
  function automatic exp_t ref_model(input logic sign, input logic [55:0] man,
                                     input logic [10:0] ex, input logic sticky,
                                     input logic [2:0] rm);
    exp_t            o;
    longint unsigned sig, frac;
    int              e;
    bit              lsb, g, r, inexact, up, ovf, toward_zero;
    logic [10:0]     ef;
    sig     = 64'(man) >> 2;
    lsb     = man[2];
    g       = man[1];
    r       = man[0];
    inexact = g || r || sticky;
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = sign && inexact;
      3'd3:    up = !sign && inexact;
      3'd4:    up = g;
      default: up = (g && (r || sticky)) || (g && !r && !sticky && lsb);
    endcase
    sig = sig + 64'(up);
    e   = int'(ex);
    if (sig >= (64'd1 << 53)) begin
      frac = (sig >> 1) & ((64'd1 << 52) - 1);
      e    = e + 1;
    end else begin
      frac = sig & ((64'd1 << 52) - 1);
      if (e == 0 && sig >= (64'd1 << 52)) e = 1;
    end
    ovf = (e >= 2047);
    if (man == '0 && ex == '0 && !sticky) begin
      o.res   = {(rm == 3'd2), 63'd0};
      o.flags = 5'd0;
    end else if (ovf) begin
      toward_zero = (rm == 3'd1) || (rm == 3'd2 && !sign) || (rm == 3'd3 && sign);
      o.res   = toward_zero ? {sign, 11'h7FE, 52'hF_FFFF_FFFF_FFFF} : {sign, 11'h7FF, 52'h0};
      o.flags = 5'b00101;
    end else begin
      ef      = e[10:0];
      o.res   = {sign, ef, frac[51:0]};
      o.flags = {3'b000, (ef == 11'd0) && inexact, inexact};
    end
    if (!FlagsOn) o.flags = 5'd0;
    return o;
  endfunction

  always @(posedge clk) begin
    #2;
    bus.out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : force_ready;
  end

  // Sampled at negedge: whatever holds here is what transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_val("hold_valid", 64'(bus.out_valid), 64'd1);
        check_val("hold_result", bus.out_result, prev_res);
        check_val("hold_flags", 64'(bus.out_flags), 64'(prev_flags));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_out", 64'(bus.out_valid), 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("out_result", bus.out_result, mon_e.res);
          check_val("out_flags", 64'(bus.out_flags), 64'(mon_e.flags));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_res   = bus.out_result;
      prev_flags = bus.out_flags;
      if (bus.in_valid && bus.in_ready) begin
        if (dir_en) begin
          mon_e.res   = dir_res;
          mon_e.flags = dir_flags;
          sb_q.push_back(mon_e);
        end else begin
          sb_q.push_back(ref_model(bus.in_sign, bus.in_man, bus.in_exp, bus.in_sticky,
                                   bus.in_rm));
        end
      end
    end
  end

  task automatic load_in(input logic s, input logic [55:0] m, input logic [10:0] e,
                         input logic st, input logic [2:0] rm);
    bus.in_valid  = 1'b1;
    bus.in_sign   = s;
    bus.in_man    = m;
    bus.in_exp    = e;
    bus.in_sticky = st;
    bus.in_rm     = rm;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (!ok) check_val("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    dir_en       = 1'b0;
  endtask

  task automatic send_dir(input logic s, input logic [55:0] m, input logic [10:0] e,
                          input logic st, input logic [2:0] rm, input logic [63:0] res,
                          input logic [4:0] flg);
    dir_en    = 1'b1;
    dir_res   = res;
    dir_flags = FlagsOn ? flg : 5'd0;
    load_in(s, m, e, st, rm);
    wait_accept();
  endtask

  task automatic gen_rnd();
    logic [55:0] m;
    logic [10:0] e;
    logic        s, st;
    logic [2:0]  rm;
    m     = 56'({$urandom(), $urandom()});
    m[55] = 1'b0;
    m[54] = 1'b1;
    e     = 11'($urandom_range(1, 2046));
    s     = 1'($urandom());
    st    = 1'($urandom());
    rm    = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: begin e = 11'($urandom_range(2045, 2047)); m[53:2] = '1; end
      1: begin e = 11'd0; m[54] = 1'b0; end
      2: begin e = 11'd0; m[54] = 1'b0; m[53:2] = '1; end
      3: begin e = 11'd0; m = '0; end
      default: ;
    endcase
    load_in(s, m, e, st, rm);
  endtask

  task automatic send_rnd();
    gen_rnd();
    wait_accept();
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int c = 0; c < 64 && !idle; c++) begin
      @(negedge clk);
      idle = (sb_q.size() == 0) && !bus.out_valid;
    end
    if (!idle) check_val("drain_timeout", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sign   = 1'b0;
    bus.in_man    = '0;
    bus.in_exp    = '0;
    bus.in_sticky = 1'b0;
    bus.in_rm     = 3'd0;
    bus.out_ready = 1'b1;
    force_ready   = 1'b1;
    bp_mode       = 1'b0;
    dir_en        = 1'b0;
    dir_res       = '0;
    dir_flags     = '0;
    prev_stall    = 1'b0;
    prev_res      = '0;
    prev_flags    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_out_result", bus.out_result, 64'd0);
    check_val("rst_out_flags", 64'(bus.out_flags), 64'd0);
    @(posedge clk);
    #1;

    send_dir(1'b0, {2'b01, 52'h1, 2'b10}, 11'h3FF, 1'b0, RNE, 64'h3FF0000000000002, 5'h01);
    send_dir(1'b0, {2'b01, 52'h0, 2'b10}, 11'h3FF, 1'b0, RNE, 64'h3FF0000000000000, 5'h01);
    send_dir(1'b0, {2'b01, 52'hF_FFFF_FFFF_FFFF, 2'b11}, 11'h3FE, 1'b0, RNE,
             64'h3FF0000000000000, 5'h01);
    send_dir(1'b0, {2'b01, 52'hF_FFFF_FFFF_FFFF, 2'b10}, 11'h7FE, 1'b0, RNE,
             64'h7FF0000000000000, 5'h05);
    // Truncation leaves the exponent at 0x7FE, so the result is exactly max finite.
    send_dir(1'b0, {2'b01, 52'hF_FFFF_FFFF_FFFF, 2'b10}, 11'h7FE, 1'b0, RTZ,
             64'h7FEFFFFFFFFFFFFF, 5'h01);
    send_dir(1'b1, {2'b01, 52'hF_FFFF_FFFF_FFFF, 2'b10}, 11'h7FE, 1'b0, RDN,
             64'hFFF0000000000000, 5'h05);
    send_dir(1'b1, {2'b01, 52'hF_FFFF_FFFF_FFFF, 2'b10}, 11'h7FE, 1'b0, RUP,
             64'hFFEFFFFFFFFFFFFF, 5'h01);
    send_dir(1'b0, 56'd0, 11'h000, 1'b0, RDN, 64'h8000000000000000, 5'h00);
    send_dir(1'b1, 56'd0, 11'h000, 1'b0, RNE, 64'h0000000000000000, 5'h00);
    send_dir(1'b0, {2'b01, 52'h2, 2'b10}, 11'h3FF, 1'b0, RMM, 64'h3FF0000000000003, 5'h01);
    send_dir(1'b0, {2'b00, 52'hF_FFFF_FFFF_FFFF, 2'b10}, 11'h000, 1'b0, RNE,
             64'h0010000000000000, 5'h01);
    send_dir(1'b0, {2'b00, 52'h5, 2'b01}, 11'h000, 1'b0, RTZ, 64'h0000000000000005, 5'h03);
    send_dir(1'b0, {2'b01, 52'h4, 2'b00}, 11'h123, 1'b1, 3'd6, 64'h1230000000000004, 5'h01);
    wait_idle();

    // Stall with a full pipe, then release and let the last three through.
    for (int i = 0; i < 3; i++) send_rnd();
    force_ready = 1'b0;
    gen_rnd();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("stall_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    force_ready = 1'b1;
    wait_accept();
    for (int i = 0; i < 2; i++) send_rnd();
    wait_idle();

    for (int i = 0; i < 3; i++) send_rnd();
    force_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_stall_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_stall_in_ready", 64'(bus.in_ready), 64'd1);
    force_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val("post_rst_quiet", 64'(bus.out_valid), 64'd0);
    end
    @(posedge clk);
    #1;

    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send_rnd();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    bp_mode     = 1'b0;
    force_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
